// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-access master: FSM states and R/W bit values.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        DEV_W   = 4'd2,
        REG     = 4'd3,
        WDATA   = 4'd4,
        RESTART = 4'd5,
        DEV_R   = 4'd6,
        RDATA   = 4'd7,
        STOP    = 4'd8,
        RESP    = 4'd9
    } state_t;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    // States whose command transmits a byte and therefore expects a slave ACK.
    function automatic logic is_byte_send(input state_t s);
        return (s == DEV_W) || (s == REG) || (s == WDATA) || (s == DEV_R);
    endfunction

endpackage

// File: rtl/i2c_reg_master.sv
// Sequences single-register I2C writes and reads as a chain of start/byte/stop
// commands issued to a downstream transaction controller.
`timescale 1ns/1ps
module i2c_reg_master
    import i2c_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rw_i,
    input  logic [6:0] req_dev_addr_i,
    input  logic [7:0] req_reg_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_nack_o,
    output logic       busy_o,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,
    output logic       start_o,
    output logic       stop_o,
    output logic       byte_send_o,
    output logic       byte_rcv_o,
    output logic       ack_en_o,
    output logic [7:0] byte_o,
    input  logic [7:0] byte_i,
    input  logic       ack_received_i
);

    state_t     state;
    state_t     next_cmd;
    logic       phase;      // 0 = ISSUE, 1 = WAIT
    logic       seen_low;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       nack_q;
    logic       in_cmd;
    logic       issue;
    logic       send_nack;
    logic [7:0] byte_val;

    assign in_cmd    = (state != IDLE) && (state != RESP);
    assign issue     = in_cmd && !phase;
    assign send_nack = is_byte_send(state) && !ack_received_i;

    always_comb begin
        next_cmd = STOP;
        case (state)
            START:   next_cmd = DEV_W;
            DEV_W:   next_cmd = ack_received_i ? REG : STOP;
            REG:     next_cmd = !ack_received_i ? STOP :
                                (rw_q == I2C_RD) ? RESTART : WDATA;
            WDATA:   next_cmd = STOP;
            RESTART: next_cmd = DEV_R;
            DEV_R:   next_cmd = ack_received_i ? RDATA : STOP;
            RDATA:   next_cmd = STOP;
            STOP:    next_cmd = RESP;
            default: next_cmd = IDLE;
        endcase
    end

    always_comb begin
        byte_val = '0;
        case (state)
            DEV_W:   byte_val = {dev_q, I2C_WR};
            REG:     byte_val = reg_q;
            WDATA:   byte_val = wdata_q;
            DEV_R:   byte_val = {dev_q, I2C_RD};
            default: byte_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            phase    <= 1'b0;
            seen_low <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= '0;
            reg_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        rw_q    <= req_rw_i;
                        dev_q   <= req_dev_addr_i;
                        reg_q   <= req_reg_addr_i;
                        wdata_q <= req_wdata_i;
                        rdata_q <= '0;
                        state   <= START;
                        phase   <= 1'b0;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    nack_q <= 1'b0;
                end
                default: begin
                    if (!phase) begin
                        if (cmd_ready_i) begin
                            phase    <= 1'b1;
                            seen_low <= 1'b0;
                        end
                    // A ready held high straight through acceptance is not completion;
                    // only a low-then-high transition ends the command.
                    end else if (!cmd_ready_i) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= next_cmd;
                        phase <= 1'b0;
                        if (send_nack)
                            nack_q <= 1'b1;
                        if (state == RDATA)
                            rdata_q <= byte_i;
                    end
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever the registered state.
    assign req_ready_o = rst_n_i && (state == IDLE);
    assign busy_o      = rst_n_i && (state != IDLE);
    assign cmd_valid_o = rst_n_i && issue;
    assign start_o     = cmd_valid_o && ((state == START) || (state == RESTART));
    assign stop_o      = cmd_valid_o && (state == STOP);
    assign byte_send_o = cmd_valid_o && is_byte_send(state);
    assign byte_rcv_o  = cmd_valid_o && (state == RDATA);
    assign ack_en_o    = 1'b0;  // single-byte read: master always NACKs the data byte
    assign byte_o      = byte_send_o ? byte_val : '0;
    assign rsp_valid_o = rst_n_i && (state == RESP);
    assign rsp_nack_o  = rsp_valid_o && nack_q;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Scoreboard bench for i2c_reg_master with a transaction-controller stub.
`timescale 1ns/1ps
module tb_i2c_reg_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_dev = '0;
    logic [7:0] req_reg = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic       start_c, stop_c, send_c, rcv_c, ack_en;
    logic [7:0] byte_out;
    logic [7:0] byte_in = '0;
    logic       ack_in = 1'b1;

    always #5 clk = ~clk;

    i2c_reg_master dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
        .req_dev_addr_i(req_dev), .req_reg_addr_i(req_reg), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_nack_o(rsp_nack),
        .busy_o(busy), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .start_o(start_c), .stop_o(stop_c), .byte_send_o(send_c), .byte_rcv_o(rcv_c),
        .ack_en_o(ack_en), .byte_o(byte_out), .byte_i(byte_in), .ack_received_i(ack_in)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] exp_cmd_q[$];
    logic [8:0]  exp_rsp_q[$];
    int hold_hi = 0;
    int nack_idx = -1;
    logic [7:0] rd_byte = '0;
    int send_idx = 0;
    bit stub_busy = 0;
    int stub_cnt = 0;
    int accepts = 0;
    int rsp_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command code: {start, stop, byte_send, byte_rcv, ack_en, byte_o}
    function automatic logic [12:0] c_start();
        return {4'b1000, 1'b0, 8'h00};
    endfunction
    function automatic logic [12:0] c_stop();
        return {4'b0100, 1'b0, 8'h00};
    endfunction
    function automatic logic [12:0] c_send(input logic [7:0] b);
        return {4'b0010, 1'b0, b};
    endfunction
    function automatic logic [12:0] c_rcv();
        return {4'b0001, 1'b0, 8'h00};
    endfunction

    function automatic logic [25:0] all_outs();
        return {req_ready, busy, cmd_valid, start_c, stop_c, send_c, rcv_c, ack_en,
                byte_out, rsp_valid, rsp_nack, rsp_rdata};
    endfunction

    // Stub + monitor: after each accepted command, ready stays high hold_hi cycles,
    // drops for two, then returns high to signal completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            stub_busy = 0;
            stub_cnt  = 0;
            cmd_ready = 1'b1;
        end else begin
            if (stub_busy) begin
                check("no_cmd_before_done", {31'd0, cmd_valid}, 32'd0);
                stub_cnt++;
                if (stub_cnt <= hold_hi) cmd_ready = 1'b1;
                else if (stub_cnt <= hold_hi + 2) cmd_ready = 1'b0;
                else begin
                    cmd_ready = 1'b1;
                    stub_busy = 0;
                end
            end else if (cmd_valid && cmd_ready) begin
                logic [12:0] got;
                got = {start_c, stop_c, send_c, rcv_c, ack_en, byte_out};
                accepts++;
                if (exp_cmd_q.size() == 0) check("cmd_unexpected", {19'd0, got}, 32'd0);
                else check("cmd", {19'd0, got}, {19'd0, exp_cmd_q.pop_front()});
                if (send_c) begin
                    ack_in = (send_idx != nack_idx);
                    send_idx++;
                end
                byte_in   = rd_byte;
                stub_busy = 1;
                stub_cnt  = 0;
            end
            if (rsp_valid) begin
                logic [8:0] gr;
                gr = {rsp_nack, rsp_rdata};
                rsp_count++;
                if (exp_rsp_q.size() == 0) check("rsp_unexpected", {23'd0, gr}, 32'h1FF);
                else check("rsp", {23'd0, gr}, {23'd0, exp_rsp_q.pop_front()});
            end
        end
    end

    task automatic issue_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd, input int hh, input int nidx,
                             input logic [7:0] rb);
        bit got_ready;
        @(posedge clk); #1;
        hold_hi = hh; nack_idx = nidx; rd_byte = rb; send_idx = 0;
        req_rw = rw; req_dev = dev; req_reg = ra; req_wdata = wd;
        req_valid = 1'b1;
        got_ready = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin got_ready = 1; break; end
        end
        check("req_ready_seen", {31'd0, got_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Scramble the request fields to show they were latched at acceptance.
        req_rw = ~rw; req_dev = ~dev; req_reg = ~ra; req_wdata = ~wd;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int hh, input int nidx,
                           input logic [7:0] rb);
        int base;
        base = rsp_count;
        issue_req(rw, dev, ra, wd, hh, nidx, rb);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (rsp_count > base) break;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rsp_pulses", rsp_count - base, 32'd1);
        check("cmd_leftover", exp_cmd_q.size(), 32'd0);
        check("idle_after_rsp", {30'd0, req_ready, busy}, 32'd2);
    endtask

    initial begin
        int base;
        int rc;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {6'd0, all_outs()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {30'd0, req_ready, busy}, 32'd2);

        // Write, all ACK
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h10), c_send(8'hA5), c_stop()};
        exp_rsp_q.push_back({1'b0, 8'h00});
        run_req(1'b0, 7'h50, 8'h10, 8'hA5, 0, -1, 8'h00);

        // Read, stub returns 0x3C
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h20), c_start(), c_send(8'hA1), c_rcv(), c_stop()};
        exp_rsp_q.push_back({1'b0, 8'h3C});
        run_req(1'b1, 7'h50, 8'h20, 8'h00, 0, -1, 8'h3C);

        // NACK on device address
        exp_cmd_q = '{c_start(), c_send(8'hA2), c_stop()};
        exp_rsp_q.push_back({1'b1, 8'h00});
        run_req(1'b0, 7'h51, 8'h10, 8'hA5, 0, 0, 8'h00);

        // NACK on register during a read: no restart
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h20), c_stop()};
        exp_rsp_q.push_back({1'b1, 8'h00});
        run_req(1'b1, 7'h50, 8'h20, 8'h00, 0, 1, 8'h3C);

        // NACK on write data
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h10), c_send(8'hA5), c_stop()};
        exp_rsp_q.push_back({1'b1, 8'h00});
        run_req(1'b0, 7'h50, 8'h10, 8'hA5, 0, 2, 8'h00);

        // NACK on read address: aborted read returns 0x00
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h33), c_start(), c_send(8'hA1), c_stop()};
        exp_rsp_q.push_back({1'b1, 8'h00});
        run_req(1'b1, 7'h50, 8'h33, 8'h00, 0, 2, 8'hEE);

        // Ready held high 3 cycles after accept
        exp_cmd_q = '{c_start(), c_send(8'h78), c_send(8'h7E), c_send(8'h81), c_stop()};
        exp_rsp_q.push_back({1'b0, 8'h00});
        run_req(1'b0, 7'h3C, 8'h7E, 8'h81, 3, -1, 8'h00);

        exp_cmd_q = '{c_start(), c_send(8'h54), c_send(8'h05), c_start(), c_send(8'h55), c_rcv(), c_stop()};
        exp_rsp_q.push_back({1'b0, 8'hC3});
        run_req(1'b1, 7'h2A, 8'h05, 8'h00, 3, -1, 8'hC3);

        // Reset during WDATA wait: no STOP, no response
        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h10), c_send(8'hA5)};
        base = accepts;
        rc = rsp_count;
        issue_req(1'b0, 7'h50, 8'h10, 8'hA5, 0, -1, 8'h00);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (accepts >= base + 4) break;
        end
        check("wdata_reached", accepts - base, 32'd4);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_outputs", {6'd0, all_outs()}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", {30'd0, req_ready, busy}, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        check("no_rsp_on_reset", rsp_count - rc, 32'd0);
        check("no_stop_on_reset", exp_cmd_q.size(), 32'd0);

        exp_cmd_q = '{c_start(), c_send(8'hA0), c_send(8'h11), c_send(8'h22), c_stop()};
        exp_rsp_q.push_back({1'b0, 8'h00});
        run_req(1'b0, 7'h50, 8'h11, 8'h22, 0, -1, 8'h00);

        check("rsp_leftover", exp_rsp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
